morse_receiver: RTL and testbench
=================================

// Module: morse_receiver
// PURPOSE
//  Receive side of the board's Morse link. Times presses on one pushbutton and classifies each as a dot or a dash.
//  Assembles the symbols into letters A..H, which is the same 3-bit letter set the LED Morse transmitter sends.
//  Reports each decoded letter as a 3-bit index with a one-cycle strobe, and shows it on one HEX display.
//  Instantiated from the DE-series top beside the transmitter, driven by CLOCK_50.
// PARAMETERS
//  UNIT_CYC  25_000_000  cycles in one Morse time unit (0.5 s at 50 MHz)
//  DASH_CYC  50_000_000  a press lasting >= this many cycles is a dash; a shorter press is a dot
//  GAP_CYC   75_000_000  release lasting this many cycles ends the letter
//  MIN_CYC   500_000     a press shorter than this is a glitch and is discarded
//  CW        27          width of the shared mark/space counter; must hold GAP_CYC
// PORTS
//  CLOCK_50   in   1  system clock
//  reset      in   1  synchronous, active-high
//  key_n      in   1  raw pushbutton, active-low, asynchronous to CLOCK_50
//  letter     out  3  index of the last letter (0=A .. 7=H)
//  letter_vld out  1  one-cycle strobe: letter is updated and valid
//  letter_err out  1  one-cycle strobe: symbol pattern was not A..H or had more than 4 symbols
//  sym_cnt    out  3  symbols collected so far for the current letter (0..4); drive to LEDR[2:0]
//  HEX0       out  7  active-low segments for the last result
// BEHAVIOUR
//  Input conditioning
//   - key_n passes through a 2-flop synchronizer; press = ~sync2.
//   - All timing uses press; the synchronizer adds 2 cycles of latency.
//  State machine: IDLE, MARK, SPACE, DECODE
//   - IDLE: wait with cnt=0. On press, go to MARK with cnt=1.
//   - MARK: cnt increments each pressed cycle and saturates at all-ones. On release:
//       cnt <  MIN_CYC  -> glitch, no symbol. Go to SPACE with cnt=0 if sym_cnt>0, otherwise go to IDLE.
//       cnt <  DASH_CYC -> shift in a dot (bit 0). Go to SPACE with cnt=0.
//       cnt >= DASH_CYC -> shift in a dash (bit 1). Go to SPACE with cnt=0.
//       If a 5th symbol arrives, set the overflow flag. sym_cnt stays at 4.
//   - SPACE: cnt increments each released cycle. A press returns to MARK with cnt=1. When cnt reaches GAP_CYC, go to DECODE.
//   - DECODE: lasts one cycle and ignores press. Next state is MARK if press is high, otherwise IDLE.
//       Clears sym_bits, sym_cnt, overflow and cnt.
//  Symbol code
//   - sym_bits[3:0] shifts left with the new symbol entering bit 0.
//   - The first symbol of the letter is therefore at bit sym_cnt-1.
//  Decode table (len:bits)
//   A 2:01  B 4:1000  C 4:1010  D 3:100  E 1:0  F 4:0010  G 3:110  H 4:0000
//  Outputs
//   - Outputs are registered and update on the clock edge that leaves DECODE.
//   - A table match: letter<=index, letter_vld=1 for one cycle, HEX0 shows the glyph A b C d E F G H.
//   - No match or overflow: letter is held, letter_err=1 for one cycle, HEX0 = 7'b0111111 (dash).
//   - letter_vld and letter_err are never high in the same cycle.
//  Reset values
//   - State IDLE, all counters 0, sync flops 1 (released).
//   - letter=0, letter_vld=0, letter_err=0, sym_cnt=0, HEX0=7'h7F (blank).
//   - Reset in any state aborts the partial letter and emits no strobe.
//  Boundaries
//   - A key held indefinitely saturates cnt and is still a single dash on release.
//   - A press exactly DASH_CYC long is a dash; a press of DASH_CYC-1 is a dot.
// STRUCTURE
//  - morse_defs.vh (shared with the transmitter):
//      `defines for state encodings, the letter index to code/length table, and HEX glyph constants.
//  - One sub-module, morse_hex_decoder: combinational map from {err, letter} to active-low 7 segments.
//  - FSM, counter, shift register and synchronizer stay in morse_receiver.
// TESTING (bench parameters: UNIT_CYC=8, DASH_CYC=16, GAP_CYC=24, MIN_CYC=2, CW=6)
//  1. Press 8 cycles, release, press 20 cycles, release 30 cycles
//       -> letter_vld pulses once, letter=0 (A), HEX0 = A glyph.
//  2. Dash, dot, dash, dot (20/8/20/8 cycle presses with 8-cycle gaps)
//       -> letter=2 (C); sym_cnt steps 1,2,3,4 then returns to 0 after DECODE.
//  3. Three dashes (20 cycles each) -> letter_err pulses once, letter is held, HEX0 = 7'b0111111.
//  4. Five dots -> overflow, so letter_err pulses once and no letter_vld.
//       Press widths 1 and 15 are recorded as no symbol and a dot respectively; a width of 16 is a dash.
//  5. Single 1-cycle glitch from IDLE -> no strobe, state returns to IDLE.
//       A glitch inside a letter (after a dot) -> only E decoded, and the gap timer restarts from the glitch.
//  6. reset asserted mid-MARK after two symbols
//       -> outputs return to reset values and no strobe; a following single dot decodes as E.

Source files
------------

// File: rtl/morse_receiver_pkg.sv
// Shared definitions for the Morse receiver: FSM encodings, symbol-to-letter table, HEX glyphs.
package morse_receiver_pkg;

  localparam int unsigned SYM_W = 4;
  localparam int unsigned LEN_W = 3;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned SEG_W = 7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MARK   = 2'd1;
  localparam logic [1:0] ST_SPACE  = 2'd2;
  localparam logic [1:0] ST_DECODE = 2'd3;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_res_t;

  // {length, shifted symbol bits} -> letter index; the first symbol sits at bit len-1
  function automatic dec_res_t decode_sym(input logic [LEN_W-1:0] len,
                                          input logic [SYM_W-1:0] bits);
    dec_res_t r;
    r.hit = 1'b1;
    r.idx = '0;
    case ({len, bits})
      7'b010_0001: r.idx = 3'd0;
      7'b100_1000: r.idx = 3'd1;
      7'b100_1010: r.idx = 3'd2;
      7'b011_0100: r.idx = 3'd3;
      7'b001_0000: r.idx = 3'd4;
      7'b100_0010: r.idx = 3'd5;
      7'b011_0110: r.idx = 3'd6;
      7'b100_0000: r.idx = 3'd7;
      default:     r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_hex_decoder.sv
// Combinational map from a decode result to active-low seven-segment glyphs (bit 6 = g .. bit 0 = a).
module morse_hex_decoder
  import morse_receiver_pkg::*;
(
  input  logic             err,
  input  logic [IDX_W-1:0] letter,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    if (!err) begin
      case (letter)
        3'd0:    seg_c = 7'b0001000;
        3'd1:    seg_c = 7'b0000011;
        3'd2:    seg_c = 7'b1000110;
        3'd3:    seg_c = 7'b0100001;
        3'd4:    seg_c = 7'b0000110;
        3'd5:    seg_c = 7'b0001110;
        3'd6:    seg_c = 7'b1000010;
        default: seg_c = 7'b0001001;
      endcase
    end
  end

endmodule

// File: rtl/morse_receiver.sv
// Morse pushbutton receiver: times presses into dots/dashes, assembles letters A..H,
// strobes the decoded index or an error and drives one HEX display.
module morse_receiver
  import morse_receiver_pkg::*;
#(
  parameter int unsigned UNIT_CYC = 25_000_000,
  parameter int unsigned DASH_CYC = 50_000_000,
  parameter int unsigned GAP_CYC  = 75_000_000,
  parameter int unsigned MIN_CYC  = 500_000,
  parameter int unsigned CW       = 27
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             key_n,
  output logic [IDX_W-1:0] letter,
  output logic             letter_vld,
  output logic             letter_err,
  output logic [LEN_W-1:0] sym_cnt,
  output logic [SEG_W-1:0] HEX0
);

  // A press lasting a full time unit is never treated as a glitch
  localparam int unsigned GLITCH_CYC = (MIN_CYC < UNIT_CYC) ? MIN_CYC : UNIT_CYC;

  logic             sync1, sync2, press;
  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [SYM_W-1:0] sym_bits, bits_nxt;
  logic [LEN_W-1:0] sym_cnt_nxt;
  logic             ovf, ovf_nxt;
  logic [IDX_W-1:0] letter_nxt;
  logic             vld_nxt, err_nxt;
  logic [SEG_W-1:0] hex_nxt, seg_c;
  logic             is_dash, dec_ok;
  dec_res_t         dec;

  // Two-flop synchronizer for the asynchronous key
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign press   = ~sync2;
  assign is_dash = (cnt >= CW'(DASH_CYC));
  assign dec     = decode_sym(sym_cnt, sym_bits);
  assign dec_ok  = dec.hit && !ovf;

  morse_hex_decoder u_hex (
    .err    (~dec_ok),
    .letter (dec.idx),
    .seg_c  (seg_c)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sym_bits   <= '0;
      sym_cnt    <= '0;
      ovf        <= 1'b0;
      letter     <= '0;
      letter_vld <= 1'b0;
      letter_err <= 1'b0;
      HEX0       <= SEG_BLANK;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sym_bits   <= bits_nxt;
      sym_cnt    <= sym_cnt_nxt;
      ovf        <= ovf_nxt;
      letter     <= letter_nxt;
      letter_vld <= vld_nxt;
      letter_err <= err_nxt;
      HEX0       <= hex_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bits_nxt    = sym_bits;
    sym_cnt_nxt = sym_cnt;
    ovf_nxt     = ovf;
    letter_nxt  = letter;
    vld_nxt     = 1'b0;
    err_nxt     = 1'b0;
    hex_nxt     = HEX0;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (press) begin
          state_nxt = ST_MARK;
          cnt_nxt   = CW'(1);
        end
      end

      ST_MARK: begin
        if (press) begin
          if (cnt != {CW{1'b1}}) cnt_nxt = cnt + CW'(1);
        end else begin
          cnt_nxt = '0;
          if (cnt < CW'(GLITCH_CYC)) begin
            state_nxt = (sym_cnt != '0) ? ST_SPACE : ST_IDLE;
          end else begin
            state_nxt = ST_SPACE;
            // A fifth symbol only marks the letter as invalid
            if (sym_cnt == LEN_W'(SYM_W)) begin
              ovf_nxt = 1'b1;
            end else begin
              bits_nxt    = {sym_bits[SYM_W-2:0], is_dash};
              sym_cnt_nxt = sym_cnt + LEN_W'(1);
            end
          end
        end
      end

      ST_SPACE: begin
        if (press) begin
          state_nxt = ST_MARK;
          cnt_nxt   = CW'(1);
        end else if (cnt >= CW'(GAP_CYC - 1)) begin
          state_nxt = ST_DECODE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      ST_DECODE: begin
        state_nxt   = press ? ST_MARK : ST_IDLE;
        cnt_nxt     = '0;
        bits_nxt    = '0;
        sym_cnt_nxt = '0;
        ovf_nxt     = 1'b0;
        hex_nxt     = seg_c;
        if (dec_ok) begin
          letter_nxt = dec.idx;
          vld_nxt    = 1'b1;
        end else begin
          err_nxt    = 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_morse_receiver.sv
// Randomized self-checking bench for morse_receiver with a pattern-string reference model.
module tb_morse_receiver;

  localparam int DASH = 16;
  localparam int MIN  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic [2:0] letter, sym_cnt;
  logic       letter_vld, letter_err;
  logic [6:0] HEX0;

  int n_chk  = 0;
  int n_fail = 0;
  int vld_seen = 0, err_seen = 0, both_seen = 0;
  int exp_letter = 0;

  string      codes[8]  = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
  logic [6:0] glyphs[8] = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001,
                            7'b0000110, 7'b0001110, 7'b1000010, 7'b0001001};
  localparam logic [6:0] DASH_GLYPH = 7'b0111111;

  always #5 clk = ~clk;

  morse_receiver #(
    .UNIT_CYC (8),
    .DASH_CYC (16),
    .GAP_CYC  (24),
    .MIN_CYC  (2),
    .CW       (6)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .key_n      (key_n),
    .letter     (letter),
    .letter_vld (letter_vld),
    .letter_err (letter_err),
    .sym_cnt    (sym_cnt),
    .HEX0       (HEX0)
  );

  always @(negedge clk) begin
    if (letter_vld) vld_seen++;
    if (letter_err) err_seen++;
    if (letter_vld && letter_err) both_seen++;
  end

  // Reference: letter index for a dot/dash string, -1 when not A..H or too long
  function automatic int model_letter(input string pat);
    if (pat.len() > 4 || pat.len() == 0) return -1;
    for (int i = 0; i < 8; i++) if (codes[i] == pat) return i;
    return -1;
  endfunction

  task automatic hold_press(input int w);
    key_n = 1'b0;
    repeat (w) @(posedge clk);
    #1 key_n = 1'b1;
  endtask

  task automatic hold_release(input int g);
    repeat (g) @(posedge clk);
    #1;
  endtask

  // Play a pattern of '.', '-' and 'g' (1-cycle glitch) with short in-letter gaps
  task automatic send_pattern(input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      byte c;
      c = pat.getc(i);
      if (c == ".")      hold_press(int'($urandom_range(MIN, DASH - 1)));
      else if (c == "-") hold_press(int'($urandom_range(DASH, DASH + 20)));
      else               hold_press(1);
      if (i != pat.len() - 1) hold_release(int'($urandom_range(3, 12)));
    end
  endtask

  task automatic wait_strobe(input int budget, output bit got);
    int v0, e0;
    v0 = vld_seen;
    e0 = err_seen;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      #1;
      if (vld_seen != v0 || err_seen != e0) got = 1'b1;
    end
    hold_release(5);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    n_chk++; if (letter !== 3'd0) begin n_fail++; $display("FAIL reset_letter: got %0d expected 0", letter); end
    n_chk++; if (letter_vld !== 1'b0 || letter_err !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got vld=%b err=%b expected 0 0", letter_vld, letter_err); end
    n_chk++; if (sym_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_sym_cnt: got %0d expected 0", sym_cnt); end
    n_chk++; if (HEX0 !== 7'h7F) begin n_fail++; $display("FAIL reset_hex: got %b expected %b", HEX0, 7'h7F); end
  endtask

  task automatic test_letter_a();
    int v0, e0; bit got;
    v0 = vld_seen; e0 = err_seen;
    hold_press(8); hold_release(8); hold_press(20);
    wait_strobe(60, got);
    exp_letter = 0;
    n_chk++; if (!got || vld_seen - v0 != 1 || err_seen != e0) begin n_fail++; $display("FAIL a_strobe: got vld=%0d err=%0d expected vld=1 err=0", vld_seen - v0, err_seen - e0); end
    n_chk++; if (letter !== 3'(exp_letter)) begin n_fail++; $display("FAIL a_letter: got %0d expected %0d", letter, exp_letter); end
    n_chk++; if (HEX0 !== glyphs[0]) begin n_fail++; $display("FAIL a_hex: got %b expected %b", HEX0, glyphs[0]); end
  endtask

  task automatic test_sym_count_c();
    int v0; bit got;
    int widths[4] = '{20, 8, 20, 8};
    v0 = vld_seen;
    for (int i = 0; i < 4; i++) begin
      hold_press(widths[i]);
      hold_release(5);
      n_chk++; if (sym_cnt !== 3'(i + 1)) begin n_fail++; $display("FAIL c_sym_cnt%0d: got %0d expected %0d", i, sym_cnt, i + 1); end
      if (i != 3) hold_release(3);
    end
    wait_strobe(60, got);
    exp_letter = 2;
    n_chk++; if (!got || vld_seen - v0 != 1) begin n_fail++; $display("FAIL c_strobe: got %0d vld pulses expected 1", vld_seen - v0); end
    n_chk++; if (letter !== 3'(exp_letter)) begin n_fail++; $display("FAIL c_letter: got %0d expected %0d", letter, exp_letter); end
    n_chk++; if (sym_cnt !== 3'd0) begin n_fail++; $display("FAIL c_sym_cnt_clear: got %0d expected 0", sym_cnt); end
  endtask

  task automatic test_bad_pattern(input string name, input string pat);
    int v0, e0; bit got;
    v0 = vld_seen; e0 = err_seen;
    send_pattern(pat);
    wait_strobe(60, got);
    n_chk++; if (!got || err_seen - e0 != 1 || vld_seen != v0) begin n_fail++; $display("FAIL %s_strobe: got vld=%0d err=%0d expected vld=0 err=1", name, vld_seen - v0, err_seen - e0); end
    n_chk++; if (letter !== 3'(exp_letter)) begin n_fail++; $display("FAIL %s_letter_held: got %0d expected %0d", name, letter, exp_letter); end
    n_chk++; if (HEX0 !== DASH_GLYPH) begin n_fail++; $display("FAIL %s_hex: got %b expected %b", name, HEX0, DASH_GLYPH); end
  endtask

  task automatic test_width_boundary();
    int v0, e0; bit got;
    v0 = vld_seen; e0 = err_seen;
    hold_press(1); hold_release(8);
    n_chk++; if (sym_cnt !== 3'd0) begin n_fail++; $display("FAIL w1_no_symbol: got %0d expected 0", sym_cnt); end
    hold_press(15); hold_release(6);
    n_chk++; if (sym_cnt !== 3'd1) begin n_fail++; $display("FAIL w15_symbol: got %0d expected 1", sym_cnt); end
    hold_release(2);
    hold_press(16);
    wait_strobe(60, got);
    exp_letter = 0;
    n_chk++; if (!got || vld_seen - v0 != 1 || err_seen != e0) begin n_fail++; $display("FAIL w15_w16_is_a: got vld=%0d err=%0d expected 1 0", vld_seen - v0, err_seen - e0); end
    n_chk++; if (letter !== 3'(exp_letter)) begin n_fail++; $display("FAIL w16_letter: got %0d expected %0d", letter, exp_letter); end
  endtask

  task automatic test_saturate();
    int v0; bit got;
    v0 = vld_seen;
    hold_press(6); hold_release(6); hold_press(150);
    wait_strobe(60, got);
    exp_letter = 0;
    n_chk++; if (!got || vld_seen - v0 != 1 || letter !== 3'(exp_letter)) begin n_fail++; $display("FAIL saturate_dash: got vld=%0d letter=%0d expected 1 %0d", vld_seen - v0, letter, exp_letter); end
  endtask

  task automatic test_glitch();
    int v0, e0; bit got;
    v0 = vld_seen; e0 = err_seen;
    hold_press(1);
    wait_strobe(60, got);
    n_chk++; if (got || sym_cnt !== 3'd0) begin n_fail++; $display("FAIL idle_glitch: got strobe=%0b sym_cnt=%0d expected 0 0", got, sym_cnt); end
    hold_press(8); hold_release(10); hold_press(1);
    hold_release(18);
    n_chk++; if (vld_seen != v0 || err_seen != e0) begin n_fail++; $display("FAIL gap_restart: got %0d early strobes expected 0", vld_seen - v0 + err_seen - e0); end
    wait_strobe(40, got);
    exp_letter = 4;
    n_chk++; if (!got || vld_seen - v0 != 1 || err_seen != e0 || letter !== 3'(exp_letter)) begin n_fail++; $display("FAIL glitch_in_letter: got vld=%0d err=%0d letter=%0d expected 1 0 %0d", vld_seen - v0, err_seen - e0, letter, exp_letter); end
  endtask

  task automatic test_reset_mid_mark();
    int v0, e0; bit got;
    hold_press(8); hold_release(8); hold_press(20); hold_release(6);
    n_chk++; if (sym_cnt !== 3'd2) begin n_fail++; $display("FAIL pre_reset_sym_cnt: got %0d expected 2", sym_cnt); end
    v0 = vld_seen; e0 = err_seen;
    key_n = 1'b0;
    hold_release(5);
    reset = 1'b1;
    hold_release(2);
    key_n = 1'b1;
    hold_release(3);
    reset = 1'b0;
    exp_letter = 0;
    n_chk++; if (letter !== 3'd0 || sym_cnt !== 3'd0 || HEX0 !== 7'h7F) begin n_fail++; $display("FAIL mid_reset_values: got letter=%0d sym_cnt=%0d hex=%b expected 0 0 1111111", letter, sym_cnt, HEX0); end
    hold_release(40);
    n_chk++; if (vld_seen != v0 || err_seen != e0) begin n_fail++; $display("FAIL mid_reset_no_strobe: got %0d strobes expected 0", vld_seen - v0 + err_seen - e0); end
    hold_press(6);
    wait_strobe(60, got);
    exp_letter = 4;
    n_chk++; if (!got || vld_seen - v0 != 1 || letter !== 3'(exp_letter)) begin n_fail++; $display("FAIL post_reset_e: got vld=%0d letter=%0d expected 1 %0d", vld_seen - v0, letter, exp_letter); end
  endtask

  task automatic test_random_letters();
    for (int it = 0; it < 14; it++) begin
      string pat, clean;
      int len, exp, v0, e0;
      bit got;
      pat = ""; clean = "";
      len = int'($urandom_range(1, 5));
      for (int s = 0; s < len; s++) begin
        if ($urandom_range(0, 1) == 1) begin pat = {pat, "-"}; clean = {clean, "-"}; end
        else                           begin pat = {pat, "."}; clean = {clean, "."}; end
        if (s != len - 1 && $urandom_range(0, 3) == 0) pat = {pat, "g"};
      end
      exp = model_letter(clean);
      v0 = vld_seen; e0 = err_seen;
      send_pattern(pat);
      wait_strobe(60, got);
      if (exp >= 0) begin
        exp_letter = exp;
        n_chk++; if (!got || vld_seen - v0 != 1 || err_seen != e0 || letter !== 3'(exp) || HEX0 !== glyphs[exp]) begin
          n_fail++; $display("FAIL rand_%s: got vld=%0d err=%0d letter=%0d hex=%b expected 1 0 %0d %b", pat, vld_seen - v0, err_seen - e0, letter, HEX0, exp, glyphs[exp]);
        end
      end else begin
        n_chk++; if (!got || err_seen - e0 != 1 || vld_seen != v0 || letter !== 3'(exp_letter) || HEX0 !== DASH_GLYPH) begin
          n_fail++; $display("FAIL rand_%s: got vld=%0d err=%0d letter=%0d hex=%b expected 0 1 %0d %b", pat, vld_seen - v0, err_seen - e0, letter, HEX0, exp_letter, DASH_GLYPH);
        end
      end
    end
  endtask

  task automatic test_exclusive_strobes();
    n_chk++; if (both_seen != 0) begin n_fail++; $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_sym_count_c();
    test_bad_pattern("three_dashes", "---");
    test_bad_pattern("five_dots", ".....");
    test_width_boundary();
    test_saturate();
    test_glitch();
    test_reset_mid_mark();
    test_random_letters();
    test_exclusive_strobes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
